toll_lane_arbiter: RTL and testbench

TOLL_LANE_ARBITER -- requirements
Module: toll_lane_arbiter

---
 rtl/toll_lane_if.sv | 25 ++
 rtl/toll_lane_arbiter.sv | 114 +++++++++++
 tb/tb_toll_lane_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/toll_lane_if.sv
// Handshake bundle between the toll lanes, the shared payment processor and the arbiter.
interface toll_lane_if;
    logic [3:0] lane_req;
    logic [7:0] lane_class;
    logic       maintenance_mode;
    logic       proc_done;
    logic       proc_ok;
    logic       proc_start;
    logic [1:0] proc_lane;
    logic [1:0] proc_class;
    logic [3:0] lane_ack;
    logic [3:0] lane_ok;
    logic       busy;
    logic [7:0] timeout_count;

    modport slave (
        input  lane_req, lane_class, maintenance_mode, proc_done, proc_ok,
        output proc_start, proc_lane, proc_class, lane_ack, lane_ok, busy, timeout_count
    );

    modport master (
        output lane_req, lane_class, maintenance_mode, proc_done, proc_ok,
        input  proc_start, proc_lane, proc_class, lane_ack, lane_ok, busy, timeout_count
    );
endinterface

// File: rtl/toll_lane_arbiter.sv
// Round-robin arbiter sharing one payment processor among four toll lanes,
// with a per-transaction watchdog and a saturating abort counter.
module toll_lane_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd20
) (
    input  logic       clk,
    input  logic       reset,
    toll_lane_if.slave bus
);
    localparam int         NUM_LANES = 4;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;
    localparam logic [7:0] TMO_LAST  = TIMEOUT - 8'd1;

    logic [1:0] state_q, state_d;
    logic [1:0] lane_q, lane_d;
    logic [1:0] class_q, class_d;
    logic [1:0] last_q, last_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic       result_q, result_d;

    logic       rr_hit;
    logic [1:0] rr_idx;
    logic [1:0] rr_cand;

    // Search starts just past the last served lane, so a lane that keeps
    // requesting after its ack lands behind every other requester.
    always_comb begin
        rr_hit  = 1'b0;
        rr_idx  = 2'd0;
        rr_cand = 2'd0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            rr_cand = last_q + 2'(k);
            if (!rr_hit && bus.lane_req[rr_cand]) begin
                rr_hit = 1'b1;
                rr_idx = rr_cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        class_d  = class_q;
        last_d   = last_q;
        timer_d  = timer_q;
        tcnt_d   = tcnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.maintenance_mode && rr_hit) begin
                    lane_d  = rr_idx;
                    class_d = bus.lane_class[{rr_idx, 1'b0} +: 2];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A real answer in the last allowed cycle beats the watchdog.
                if (bus.proc_done) begin
                    result_d = bus.proc_ok;
                    state_d  = S_RESP;
                end else if (timer_q == TMO_LAST) begin
                    result_d = 1'b0;
                    tcnt_d   = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
                    state_d  = S_RESP;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: begin
                last_d  = lane_q;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            lane_q   <= 2'd0;
            class_q  <= 2'd0;
            last_q   <= 2'd3;
            timer_q  <= 8'd0;
            tcnt_q   <= 8'd0;
            result_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            class_q  <= class_d;
            last_q   <= last_d;
            timer_q  <= timer_d;
            tcnt_q   <= tcnt_d;
            result_q <= result_d;
        end
    end

    assign bus.proc_start    = (state_q == S_ISSUE);
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.proc_lane     = lane_q;
    assign bus.proc_class    = class_q;
    assign bus.timeout_count = tcnt_q;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign bus.lane_ack[i] = (state_q == S_RESP) && (lane_q == 2'(i));
        assign bus.lane_ok[i]  = (state_q == S_RESP) && (lane_q == 2'(i)) && result_q;
    end
endmodule

// File: tb/tb_toll_lane_arbiter.sv
// Directed bench: a vector table of single transactions plus hand-written
// sequences for round-robin, watchdog, maintenance and mid-transaction reset.
module tb_toll_lane_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    toll_lane_if bus();

    toll_lane_arbiter #(.TIMEOUT(8'd20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] req;
        logic [7:0] cls;
        logic       ok;
        logic [1:0] lane;
        logic [1:0] pcls;
        logic [3:0] ack;
        logic [3:0] lok;
    } vec_t;

    vec_t tbl[6];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_start", 32'(bus.proc_start), 32'd0);
        chk("rst_ack",   32'(bus.lane_ack), 32'd0);
        chk("rst_ok",    32'(bus.lane_ok), 32'd0);
        chk("rst_lane",  32'(bus.proc_lane), 32'd0);
        chk("rst_class", 32'(bus.proc_class), 32'd0);
        chk("rst_tcnt",  32'(bus.timeout_count), 32'd0);
        reset = 1'b0;
    endtask

    // One full transaction answered in the first WAIT cycle; the request and
    // the class inputs are disturbed mid-flight to prove they were latched.
    task automatic txn(input vec_t v);
        bus.lane_req   = v.req;
        bus.lane_class = v.cls;
        tick;
        chk("issue_start", 32'(bus.proc_start), 32'd1);
        chk("issue_lane",  32'(bus.proc_lane), 32'(v.lane));
        chk("issue_class", 32'(bus.proc_class), 32'(v.pcls));
        bus.lane_req   = 4'b0000;
        bus.lane_class = ~v.cls;
        tick;
        chk("wait_start", 32'(bus.proc_start), 32'd0);
        chk("wait_ack",   32'(bus.lane_ack), 32'd0);
        bus.proc_done = 1'b1;
        bus.proc_ok   = v.ok;
        tick;
        chk("resp_ack",   32'(bus.lane_ack), 32'(v.ack));
        chk("resp_ok",    32'(bus.lane_ok), 32'(v.lok));
        chk("resp_class", 32'(bus.proc_class), 32'(v.pcls));
        bus.proc_done = 1'b0;
        bus.proc_ok   = 1'b0;
        tick;
        chk("idle_ack",  32'(bus.lane_ack), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic timeout_txn(input logic [1:0] lane, input bit check, input logic [7:0] exp_cnt);
        bus.lane_req = 4'(1) << lane;
        tick;
        tick;
        repeat (19) tick;
        if (check) begin
            chk("tmo_pre_ack",  32'(bus.lane_ack), 32'd0);
            chk("tmo_pre_busy", 32'(bus.busy), 32'd1);
        end
        tick;
        if (check) begin
            chk("tmo_ack",  32'(bus.lane_ack), 32'(4'(1) << lane));
            chk("tmo_ok",   32'(bus.lane_ok), 32'd0);
            chk("tmo_cnt",  32'(bus.timeout_count), 32'(exp_cnt));
        end
        bus.lane_req = 4'b0000;
        tick;
    endtask

    task automatic late_done(input logic ok, input logic [3:0] exp_ok);
        bus.lane_req = 4'b0010;
        tick;
        tick;
        repeat (19) tick;
        bus.proc_done = 1'b1;
        bus.proc_ok   = ok;
        tick;
        chk("late_ack", 32'(bus.lane_ack), 32'h2);
        chk("late_ok",  32'(bus.lane_ok), 32'(exp_ok));
        chk("late_cnt", 32'(bus.timeout_count), 32'd1);
        bus.lane_req  = 4'b0000;
        bus.proc_done = 1'b0;
        bus.proc_ok   = 1'b0;
        tick;
    endtask

    initial begin
        logic [1:0] prev_lane;
        vec_t       v2;

        tbl[0] = '{4'b0001, 8'b0000_0001, 1'b1, 2'd0, 2'd1, 4'b0001, 4'b0001};
        tbl[1] = '{4'b0100, 8'b0011_0000, 1'b0, 2'd2, 2'd3, 4'b0100, 4'b0000};
        tbl[2] = '{4'b0011, 8'b0000_1001, 1'b1, 2'd0, 2'd1, 4'b0001, 4'b0001};
        tbl[3] = '{4'b0011, 8'b0000_1001, 1'b1, 2'd1, 2'd2, 4'b0010, 4'b0010};
        tbl[4] = '{4'b1010, 8'b1100_0000, 1'b0, 2'd3, 2'd3, 4'b1000, 4'b0000};
        tbl[5] = '{4'b1010, 8'b0100_1000, 1'b1, 2'd1, 2'd2, 4'b0010, 4'b0010};

        bus.lane_req         = 4'b0000;
        bus.lane_class       = 8'h00;
        bus.maintenance_mode = 1'b0;
        bus.proc_done        = 1'b0;
        bus.proc_ok          = 1'b0;
        reset                = 1'b0;
        tick;
        do_reset;

        for (int i = 0; i < 6; i++) txn(tbl[i]);

        // All lanes held high: strict rotation starting at lane 0.
        do_reset;
        bus.lane_req   = 4'b1111;
        bus.lane_class = 8'hE4;
        prev_lane      = 2'd3;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("rr_lane", 32'(bus.proc_lane), 32'(i % 4));
            chk("rr_norepeat", 32'(bus.proc_lane != prev_lane), 32'd1);
            prev_lane = bus.proc_lane;
            tick;
            bus.proc_done = 1'b1;
            bus.proc_ok   = 1'b1;
            tick;
            chk("rr_ack", 32'(bus.lane_ack), 32'(4'(1) << (i % 4)));
            bus.proc_done = 1'b0;
            tick;
        end
        bus.lane_req = 4'b0000;
        tick;

        timeout_txn(2'd2, 1'b1, 8'd1);
        late_done(1'b0, 4'b0000);
        late_done(1'b1, 4'b0010);

        // Maintenance blocks new grants but not the one in flight.
        bus.maintenance_mode = 1'b1;
        bus.lane_req         = 4'b0010;
        repeat (4) begin
            tick;
            chk("mnt_start", 32'(bus.proc_start), 32'd0);
            chk("mnt_busy",  32'(bus.busy), 32'd0);
        end
        bus.maintenance_mode = 1'b0;
        tick;
        chk("mnt_issue", 32'(bus.proc_start), 32'd1);
        chk("mnt_lane",  32'(bus.proc_lane), 32'd1);
        tick;
        bus.maintenance_mode = 1'b1;
        tick;
        chk("mnt_wait_busy", 32'(bus.busy), 32'd1);
        bus.proc_done = 1'b1;
        bus.proc_ok   = 1'b1;
        tick;
        chk("mnt_ack", 32'(bus.lane_ack), 32'h2);
        chk("mnt_ok",  32'(bus.lane_ok), 32'h2);
        bus.proc_done = 1'b0;
        bus.proc_ok   = 1'b0;
        repeat (3) begin
            tick;
            chk("mnt_hold_start", 32'(bus.proc_start), 32'd0);
            chk("mnt_hold_busy",  32'(bus.busy), 32'd0);
        end
        bus.maintenance_mode = 1'b0;
        tick;
        chk("mnt_regrant", 32'(bus.proc_start), 32'd1);
        bus.lane_req = 4'b0000;
        tick;
        bus.proc_done = 1'b1;
        tick;
        bus.proc_done = 1'b0;
        tick;

        // Reset while waiting on lane 3: priority returns to lane 0.
        v2 = '{4'b0100, 8'h00, 1'b1, 2'd2, 2'd0, 4'b0100, 4'b0100};
        txn(v2);
        bus.lane_req = 4'b1001;
        tick;
        chk("pre_rst_lane", 32'(bus.proc_lane), 32'd3);
        tick;
        tick;
        reset = 1'b1;
        #1;
        chk("arst_busy",  32'(bus.busy), 32'd0);
        chk("arst_ack",   32'(bus.lane_ack), 32'd0);
        chk("arst_start", 32'(bus.proc_start), 32'd0);
        chk("arst_lane",  32'(bus.proc_lane), 32'd0);
        chk("arst_tcnt",  32'(bus.timeout_count), 32'd0);
        tick;
        reset = 1'b0;
        tick;
        chk("post_rst_start", 32'(bus.proc_start), 32'd1);
        chk("post_rst_lane",  32'(bus.proc_lane), 32'd0);
        bus.lane_req = 4'b0000;
        tick;
        bus.proc_done = 1'b1;
        bus.proc_ok   = 1'b1;
        tick;
        chk("post_rst_ack", 32'(bus.lane_ack), 32'h1);
        bus.proc_done = 1'b0;
        bus.proc_ok   = 1'b0;
        tick;

        for (int i = 0; i < 260; i++) begin
            timeout_txn(2'd2, 1'b0, 8'd0);
            chk("sat_cnt", 32'(bus.timeout_count), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
